// File: rtl/tdc_capture_decoder.sv
// TDC launch/capture/decode controller: fires the delay line, double-flops the taps,
// and reports a thermometer-to-binary count with range and bubble flags over valid/ready.
module tdc_capture_decoder #(
    parameter int unsigned N      = 64,
    parameter bit          INVERT = 1'b1,
    parameter int unsigned SETTLE = 4,
    parameter int unsigned CNT_W  = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arm,
    output logic             launch,
    input  logic [N-1:0]     dl_taps,
    output logic             busy,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    output logic             underflow,
    output logic             bubble
);

    localparam int unsigned DIS_W = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LAUNCH    = 3'd1,
        SYNC      = 3'd2,
        DECODE    = 3'd3,
        VALID     = 3'd4,
        DISCHARGE = 3'd5
    } state_t;

    state_t             state;
    logic [N-1:0]       stage1;
    logic [N-1:0]       stage2;
    logic [DIS_W-1:0]   dis_cnt;

    logic [N-1:0]       t_c;
    logic [CNT_W-1:0]   pop_c;
    logic               thermo_c;

    // Decode the synchronized code: popcount plus a check that set bits form a contiguous run from bit 0
    always_comb begin
        t_c      = INVERT ? ~stage2 : stage2;
        pop_c    = '0;
        thermo_c = 1'b1;
        for (int i = 0; i < int'(N); i++) begin
            pop_c = pop_c + CNT_W'(t_c[i]);
        end
        for (int i = 0; i < int'(N); i++) begin
            if (t_c[i] != (i < int'(pop_c))) begin
                thermo_c = 1'b0;
            end
        end
    end

    // Measurement sequencer with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            launch       <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            count        <= '0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
            bubble       <= 1'b0;
            stage1       <= '0;
            stage2       <= '0;
            dis_cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (arm) begin
                        state  <= LAUNCH;
                        launch <= 1'b1;
                        busy   <= 1'b1;
                    end
                end
                LAUNCH: begin
                    stage1 <= dl_taps;
                    launch <= 1'b0;
                    state  <= SYNC;
                end
                SYNC: begin
                    stage2 <= stage1;
                    state  <= DECODE;
                end
                DECODE: begin
                    count        <= pop_c;
                    overflow     <= (pop_c == CNT_W'(N));
                    underflow    <= (pop_c == '0);
                    bubble       <= ~thermo_c;
                    result_valid <= 1'b1;
                    state        <= VALID;
                end
                VALID: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        dis_cnt      <= DIS_W'(SETTLE);
                        state        <= DISCHARGE;
                    end
                end
                DISCHARGE: begin
                    // Line must stay undriven for SETTLE full cycles before the next launch
                    if (dis_cnt <= DIS_W'(1)) begin
                        dis_cnt <= '0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        dis_cnt <= dis_cnt - DIS_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tdc_capture_decoder.sv
// Scoreboard bench for tdc_capture_decoder: expected decodes are queued when taps are driven
// and compared when each result is presented.
module tb_tdc_capture_decoder;

    localparam int unsigned N      = 64;
    localparam int unsigned CNT_W  = 7;
    localparam int unsigned SETTLE = 4;

    logic             clk;
    logic             rst;
    logic             arm;
    logic             launch;
    logic [N-1:0]     dl_taps;
    logic             busy;
    logic             result_valid;
    logic             result_ready;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             underflow;
    logic             bubble;

    logic             arm2;
    logic             launch2;
    logic             busy2;
    logic             result_valid2;
    logic             result_ready2;
    logic [CNT_W-1:0] count2;
    logic             overflow2;
    logic             underflow2;
    logic             bubble2;

    int checks = 0;
    int errors = 0;
    logic [9:0] exp_q[$];

    tdc_capture_decoder #(.N(N), .INVERT(1'b1), .SETTLE(SETTLE), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .rst(rst), .arm(arm), .launch(launch), .dl_taps(dl_taps), .busy(busy),
        .result_valid(result_valid), .result_ready(result_ready), .count(count),
        .overflow(overflow), .underflow(underflow), .bubble(bubble)
    );

    tdc_capture_decoder #(.N(N), .INVERT(1'b0), .SETTLE(SETTLE), .CNT_W(CNT_W)) u_dut_noinv (
        .clk(clk), .rst(rst), .arm(arm2), .launch(launch2), .dl_taps(dl_taps), .busy(busy2),
        .result_valid(result_valid2), .result_ready(result_ready2), .count(count2),
        .overflow(overflow2), .underflow(underflow2), .bubble(bubble2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference decode: {count, overflow, underflow, bubble}
    function automatic logic [9:0] model(input logic [63:0] taps, input bit inv);
        logic [63:0] t;
        logic [63:0] mask;
        int c;
        t = inv ? ~taps : taps;
        c = $countones(t);
        mask = (c == 64) ? {64{1'b1}} : ((64'd1 << c) - 64'd1);
        return {7'(c), (c == 64), (c == 0), (t != mask)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One measurement on the inverting instance; hold = cycles result_ready stays low in VALID
    task automatic measure(input logic [63:0] taps, input int hold, input string tag);
        int lat;
        int launch_hi;
        int dis;
        logic [9:0] snap;
        logic [9:0] exp;
        dl_taps = taps;
        exp_q.push_back(model(taps, 1'b1));
        result_ready = (hold == 0);
        arm = 1'b1;
        step();
        check({tag, ".launch_up"}, 64'(launch), 64'd1);
        check({tag, ".busy_up"}, 64'(busy), 64'd1);
        arm = 1'b0;
        lat = 0;
        launch_hi = 0;
        while (!result_valid && lat < 12) begin
            step();
            lat++;
            if (launch) launch_hi++;
        end
        check({tag, ".latency"}, 64'(lat), 64'd3);
        check({tag, ".launch_width"}, 64'(launch_hi), 64'd0);
        snap = {count, overflow, underflow, bubble};
        for (int k = 0; k < hold; k++) begin
            arm = 1'($urandom_range(0, 1));
            result_ready = 1'b0;
            step();
            check({tag, ".hold_valid"}, 64'(result_valid), 64'd1);
            check({tag, ".hold_nolaunch"}, 64'(launch), 64'd0);
            check({tag, ".hold_stable"}, 64'({count, overflow, underflow, bubble}), 64'(snap));
        end
        arm = 1'b0;
        result_ready = 1'b1;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 10'h3ff;
        check({tag, ".result"}, 64'({count, overflow, underflow, bubble}), 64'(exp));
        step();
        result_ready = 1'b0;
        check({tag, ".valid_drop"}, 64'(result_valid), 64'd0);
        dis = 0;
        while (busy && dis < 30) begin
            step();
            dis++;
        end
        check({tag, ".discharge"}, 64'(dis), 64'(SETTLE));
        check({tag, ".result_kept"}, 64'({count, overflow, underflow, bubble}), 64'(exp));
    endtask

    initial begin
        logic [63:0] t;
        int c;
        logic [9:0] exp;
        int lat;
        rst = 1'b1;
        arm = 1'b0;
        arm2 = 1'b0;
        result_ready = 1'b0;
        result_ready2 = 1'b1;
        dl_taps = '1;
        repeat (3) step();
        check("rst.launch", 64'(launch), 64'd0);
        check("rst.busy", 64'(busy), 64'd0);
        check("rst.valid", 64'(result_valid), 64'd0);
        check("rst.fields", 64'({count, overflow, underflow, bubble}), 64'd0);
        rst = 1'b0;
        step();

        measure(64'hFFFF_FFFF_FFFF_F000, 0, "cnt12");
        measure(64'hFFFF_FFFF_FFFF_F010, 0, "bubble11");
        measure(64'h0, 0, "ovf");
        measure({64{1'b1}}, 0, "unf");
        measure(64'hFFFF_FFFF_FFFF_FF00, 5, "hold5");

        // Reset asserted mid-cycle while in SYNC
        dl_taps = 64'hFFFF_FFFF_0000_0000;
        arm = 1'b1;
        step();
        arm = 1'b0;
        step();
        #2 rst = 1'b1;
        #1;
        check("arst.launch", 64'(launch), 64'd0);
        check("arst.busy", 64'(busy), 64'd0);
        check("arst.valid", 64'(result_valid), 64'd0);
        step();
        #2 rst = 1'b0;
        lat = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (result_valid || busy) lat++;
        end
        check("arst.no_result", 64'(lat), 64'd0);
        measure(64'hFFFF_FFFF_0000_0000, 0, "post_rst");

        // Randomized thermometer codes, some with a single flipped bit
        for (int r = 0; r < 6; r++) begin
            c = $urandom_range(0, 64);
            t = (c == 64) ? {64{1'b1}} : ((64'd1 << c) - 64'd1);
            if (r % 2 == 1) t[$urandom_range(0, 63)] ^= 1'b1;
            measure(~t, r % 3, "rand");
        end

        // Non-inverting instance
        dl_taps = 64'h0000_0000_0000_00FF;
        exp_q.push_back(model(dl_taps, 1'b0));
        arm2 = 1'b1;
        step();
        arm2 = 1'b0;
        lat = 0;
        while (!result_valid2 && lat < 12) begin
            step();
            lat++;
        end
        check("noinv.latency", 64'(lat), 64'd3);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 10'h3ff;
        check("noinv.result", 64'({count2, overflow2, underflow2, bubble2}), 64'(exp));
        check("noinv.count8", 64'(count2), 64'd8);
        repeat (SETTLE + 2) step();
        check("noinv.idle", 64'(busy2), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tdc_capture_decoder.md
Name: tdc_capture_decoder

Overview:
- Launch/capture/decode controller for the TDC delay line. Drives the line's launch input, samples the N tap outputs through a two-flop capture stage, and converts the thermometer code to a binary count with range and bubble flags.
- Presents each result on a valid/ready interface to downstream logic, then holds launch low until the line has discharged before accepting the next measurement.

Parameters:
- N, 64, number of delay-line taps.
- INVERT, 1, 1 = taps rest at all-ones and zeros fill from bit 0, so taps are inverted before decode; 0 = taps used as-is.
- SETTLE, 4, discharge cycles (launch held low) after a result handshake; legal range is 1..255.
- CNT_W, $clog2(N+1), width of the count output (7 for N=64).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- arm  input  1  request one measurement; sampled only in IDLE
- launch  output  1  drives the delay-line input
- dl_taps  input  N  delay-line tap outputs, asynchronous to clk
- busy  output  1  high in every state except IDLE
- result_valid  output  1  result available
- result_ready  input  1  downstream accepts result
- count  output  CNT_W  number of set bits in the decoded code t
- overflow  output  1  t is all ones (edge ran past the end of the line)
- underflow  output  1  t is all zeros (edge did not enter the line)
- bubble  output  1  t is not a pure thermometer code

Behaviour:
- Decoded code: t = INVERT ? ~stage2 : stage2. Bit 0 is the tap nearest the launch input.
- Reset (asynchronous, takes effect immediately mid-operation): state IDLE; launch, busy, result_valid, count, overflow, underflow, bubble, stage1, stage2 all 0; discharge counter 0. All outputs are registered.
- FSM states: IDLE, LAUNCH, SYNC, DECODE, VALID, DISCHARGE.
- IDLE: on an edge with arm=1, go to LAUNCH and set launch=1. Otherwise stay in IDLE.
- LAUNCH (1 cycle): at the next edge (k1), stage1<=dl_taps, launch<=0, go to SYNC.
- SYNC (1 cycle): at edge k2, stage2<=stage1, go to DECODE.
- DECODE (1 cycle): at edge k3, register the decoded fields and set result_valid=1, go to VALID.
  - count = popcount(t).
  - overflow = (count==N).
  - underflow = (count==0).
  - bubble = (t != 2^count - 1). All-zeros and all-ones codes are not bubbles.
- Latency: launch is high for exactly one clk period. result_valid rises 3 edges after launch rises.
- VALID: count and all flags hold stable and result_valid stays 1 until an edge with result_ready=1. On that edge, result_valid<=0, load the discharge counter with SETTLE, go to DISCHARGE.
- DISCHARGE: decrement each edge; after exactly SETTLE cycles in DISCHARGE, go to IDLE.
- arm is ignored in every state except IDLE; no queuing. In IDLE it is level-sensitive: arm held high starts back-to-back measurements.
- result_ready is ignored outside VALID.
- count and flags keep their last value after the handshake until the next DECODE overwrites them.
- Minimum measurement period: 4 + SETTLE + (number of cycles waiting in VALID) cycles, plus one IDLE cycle.

Test Plan:
- N=64, INVERT=1, SETTLE=4, dl_taps=64'hFFFF_FFFF_FFFF_F000, arm pulse 1 cycle, result_ready=1 -> launch high for exactly 1 cycle; result_valid rises 3 cycles after launch; count=12, no flags; busy drops 4 cycles after the handshake.
- dl_taps=64'hFFFF_FFFF_FFFF_F010 (t=0x0000_0000_0000_0FEF) -> count=11, bubble=1, overflow=0, underflow=0.
- dl_taps=64'h0 -> count=64, overflow=1. dl_taps=all ones -> count=0, underflow=1, bubble=0.
- result_ready=0 for 5 cycles after result_valid, arm toggling throughout -> count and flags stable, no new launch; handshake on cycle 6, then DISCHARGE lasts 4 cycles and the next arm is accepted.
- rst asserted while in SYNC with launch history pending -> launch, busy, result_valid go 0 immediately (asynchronously); no result_valid after release; a fresh arm gives a correct measurement.
- INVERT=0, dl_taps=64'h0000_0000_0000_00FF -> count=8, no flags.
